// File: rtl/dmem_arbiter_if.sv
// Line-memory request bus: enable/write/addr/wdata out, rdata/ack back.
// The requester uses the master modport; the responder uses the slave modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output enable, write, addr, wdata, input rdata, ack);
    modport slave  (input enable, write, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one line data memory between I-cache (m0) and
// D-cache (m1), with a watchdog that abandons grants the memory never acks.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TMO_CYC = 1023,
    parameter int TMO_W   = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_arbiter_if.slave         m0_if,
    dmem_arbiter_if.slave         m1_if,
    dmem_arbiter_if.master        mem_if,
    output logic [1:0]            gnt_o,
    output logic                  tmo_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam bit               TMO_ON  = (TMO_CYC != 0);
    localparam logic [TMO_W:0]   TMO_LIM = TMO_CYC[TMO_W:0];

    state_e            state_q, state_d;
    logic              last_q, last_d;     // 1: m1 served last, so m0 wins a tie
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              err_q, err_d;

    logic              granted, gnt1;
    logic              sel_en, sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [TMO_W:0]    wdog_inc;

    assign granted  = (state_q != IDLE);
    assign gnt1     = (state_q == GNT1);
    assign sel_en   = gnt1 ? m1_if.enable : m0_if.enable;
    assign sel_wr   = gnt1 ? m1_if.write  : m0_if.write;
    assign sel_addr = gnt1 ? m1_if.addr   : m0_if.addr;
    assign sel_data = gnt1 ? m1_if.wdata  : m0_if.wdata;
    // Count including the current granted cycle, so the limit hits on cycle TMO_CYC.
    assign wdog_inc = {1'b0, wdog_q} + {{TMO_W{1'b0}}, 1'b1};

    assign gnt_o     = {state_q == GNT1, state_q == GNT0};
    assign tmo_err_o = err_q;

    // Request forwarding is combinational so an abort drops mem enable at once.
    always_comb begin
        mem_if.enable = 1'b0;
        mem_if.write  = 1'b0;
        mem_if.addr   = '0;
        mem_if.wdata  = '0;
        m0_if.ack     = 1'b0;
        m1_if.ack     = 1'b0;
        m0_if.rdata   = '0;
        m1_if.rdata   = '0;
        if (granted) begin
            mem_if.enable = sel_en;
            mem_if.write  = sel_wr;
            mem_if.addr   = sel_addr;
            mem_if.wdata  = sel_data;
            m0_if.rdata   = mem_if.rdata;
            m1_if.rdata   = mem_if.rdata;
            m0_if.ack     = ~gnt1 & mem_if.ack;
            m1_if.ack     =  gnt1 & mem_if.ack;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (m0_if.enable && m1_if.enable)
                    state_d = last_q ? GNT0 : GNT1;
                else if (m0_if.enable)
                    state_d = GNT0;
                else if (m1_if.enable)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                // Priority: ack, then abort, then timeout.
                if (mem_if.ack) begin
                    state_d = IDLE;
                    last_d  = gnt1;
                    wdog_d  = '0;
                end else if (!sel_en) begin
                    state_d = IDLE;
                    wdog_d  = '0;
                end else if (TMO_ON && (wdog_inc == TMO_LIM)) begin
                    state_d = IDLE;
                    last_d  = gnt1;
                    err_d   = 1'b1;
                    wdog_d  = '0;
                end else begin
                    wdog_d  = wdog_inc[TMO_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (default watchdog and 8-cycle
// watchdog) share one stimulus; a per-cycle model plus literal pins check both.
module tb_dmem_arbiter;

    localparam logic [255:0] PAT_A = {8{32'hA5A5_1234}};
    localparam logic [255:0] WD0   = {8{32'h0D0D_0000}};
    localparam logic [255:0] WD1   = {8{32'h1D1D_1111}};

    logic         clk;
    logic         rst;
    logic         en0, wr0, en1, wr1, mack;
    logic [31:0]  a0, a1;
    logic [255:0] d0, d1, mdata;
    logic [1:0]   gnt_a, gnt_b;
    logic         err_a, err_b;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if ia0 (), ia1 (), iam ();
    dmem_arbiter_if ib0 (), ib1 (), ibm ();

    assign ia0.enable = en0; assign ia0.write = wr0; assign ia0.addr = a0; assign ia0.wdata = d0;
    assign ia1.enable = en1; assign ia1.write = wr1; assign ia1.addr = a1; assign ia1.wdata = d1;
    assign ib0.enable = en0; assign ib0.write = wr0; assign ib0.addr = a0; assign ib0.wdata = d0;
    assign ib1.enable = en1; assign ib1.write = wr1; assign ib1.addr = a1; assign ib1.wdata = d1;
    assign iam.ack = mack;   assign iam.rdata = mdata;
    assign ibm.ack = mack;   assign ibm.rdata = mdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(256), .TMO_CYC(1023), .TMO_W(10)) dut_a (
        .clk_i(clk), .rst_i(rst), .m0_if(ia0), .m1_if(ia1), .mem_if(iam),
        .gnt_o(gnt_a), .tmo_err_o(err_a));

    dmem_arbiter #(.ADDR_W(32), .DATA_W(256), .TMO_CYC(8), .TMO_W(10)) dut_b (
        .clk_i(clk), .rst_i(rst), .m0_if(ib0), .m1_if(ib1), .mem_if(ibm),
        .gnt_o(gnt_b), .tmo_err_o(err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: owner 0=none, 1=m0, 2=m1; prev = master served last; age = granted cycles done.
    int owner [2];
    int prev  [2];
    int age   [2];
    bit merr  [2];
    int tmo_of[2] = '{1023, 8};

    task automatic model_cmp(input int i, input string tg,
                             input logic [1:0] g, input logic men, input logic mwr,
                             input logic [31:0] madr, input logic [255:0] mdo,
                             input logic k0, input logic k1,
                             input logic [255:0] r0, input logic [255:0] r1, input logic er);
        logic [1:0]   eg;
        logic         emen, ewr, ek0, ek1;
        logic [31:0]  eadr;
        logic [255:0] edat;
        eg = 2'b00; emen = 1'b0; ewr = 1'b0; eadr = '0; edat = '0; ek0 = 1'b0; ek1 = 1'b0;
        if (owner[i] == 1) begin
            eg = 2'b01; emen = en0; ewr = wr0; eadr = a0; edat = d0; ek0 = mack;
        end else if (owner[i] == 2) begin
            eg = 2'b10; emen = en1; ewr = wr1; eadr = a1; edat = d1; ek1 = mack;
        end
        chk({tg, " gnt"}, g, eg);
        chk({tg, " mem_en"}, men, emen);
        chk({tg, " mem_wr"}, mwr, ewr);
        chk({tg, " mem_addr"}, madr, eadr);
        chk({tg, " mem_wdata"}, mdo, edat);
        chk({tg, " ack0"}, k0, ek0);
        chk({tg, " ack1"}, k1, ek1);
        chk({tg, " tmo_err"}, er, merr[i]);
        if (owner[i] != 0) begin
            chk({tg, " rdata0"}, r0, mdata);
            chk({tg, " rdata1"}, r1, mdata);
        end else if (!rst) begin
            chk({tg, " rdata0_rst"}, r0, 256'd0);
            chk({tg, " rdata1_rst"}, r1, 256'd0);
        end
    endtask

    task automatic model_step(input int i);
        int  k, n;
        bit  ek;
        if (owner[i] == 0) begin
            age[i] = 0;
            if (en0 && en1) owner[i] = (prev[i] == 0) ? 2 : 1;
            else if (en0)   owner[i] = 1;
            else if (en1)   owner[i] = 2;
        end else begin
            k  = owner[i] - 1;
            n  = age[i] + 1;
            ek = (k == 1) ? en1 : en0;
            if (mack) begin
                prev[i] = k; owner[i] = 0;
            end else if (!ek) begin
                owner[i] = 0;
            end else if (tmo_of[i] != 0 && n >= tmo_of[i]) begin
                owner[i] = 0; merr[i] = 1'b1; prev[i] = k;
            end else begin
                age[i] = n;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                owner[i] = 0; prev[i] = 1; age[i] = 0; merr[i] = 1'b0;
            end
        end
        model_cmp(0, "A", gnt_a, iam.enable, iam.write, iam.addr, iam.wdata,
                  ia0.ack, ia1.ack, ia0.rdata, ia1.rdata, err_a);
        model_cmp(1, "B", gnt_b, ibm.enable, ibm.write, ibm.addr, ibm.wdata,
                  ib0.ack, ib1.ack, ib0.rdata, ib1.rdata, err_b);
        if (rst) begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of inputs applied just after the edge; outputs settle before return.
    task automatic cyc(input bit e0, input bit w0, input logic [31:0] ad0,
                       input bit e1, input bit w1, input logic [31:0] ad1, input bit ak);
        tick();
        en0 = e0; wr0 = w0; a0 = ad0;
        en1 = e1; wr1 = w1; a1 = ad1;
        mack = ak;
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0; en0 = 1'b0; en1 = 1'b0; mack = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = WD0;
        en1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = WD1;
        mack = 1'b0; mdata = PAT_A;
        #1;
        // T1: reset with both masters requesting
        rst = 1'b0; en0 = 1'b1; en1 = 1'b1; mack = 1'b1;
        #1;
        chk("T1 gnt_in_reset", gnt_a, 2'b00);
        chk("T1 mem_en_in_reset", iam.enable, 1'b0);
        chk("T1 ack0_in_reset", ia0.ack, 1'b0);
        chk("T1 ack1_in_reset", ia1.ack, 1'b0);
        chk("T1 rdata1_in_reset", ia1.rdata, 256'd0);
        tick();
        mack = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("T1 gnt_release", gnt_a, 2'b00);
        cyc(1, 0, 32'h40, 1, 0, 32'h80, 0);
        chk("T1 first_grant", gnt_a, 2'b01);
        chk("T1 first_addr", iam.addr, 32'h40);
        cyc(0, 0, 32'h40, 0, 0, 32'h80, 0);
        chk("T1 abort_drop", iam.enable, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("T1 idle", gnt_a, 2'b00);

        // T2: single m1 read, ack on the 10th granted cycle
        do_reset();
        cyc(0, 0, 0, 1, 0, 32'h420, 0);
        chk("T2 gnt_c0", gnt_a, 2'b00);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 1, 0, 32'h420, k == 10);
            chk("T2 gnt", gnt_a, 2'b10);
            chk("T2 addr", iam.addr, 32'h420);
            chk("T2 wr", iam.write, 1'b0);
            chk("T2 ack1", ia1.ack, k == 10);
            chk("T2 ack0", ia0.ack, 1'b0);
            if (k == 10) chk("T2 rdata1", ia1.rdata, PAT_A);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("T2 gnt_after", gnt_a, 2'b00);

        // T3: contention, acks on every 3rd granted cycle
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            logic [1:0] eg;
            cyc(1, 0, 32'h100, 1, 1, 32'h200, (c % 4) == 3);
            eg = ((c % 4) == 0) ? 2'b00 : ((((c / 4) % 2) == 1) ? 2'b10 : 2'b01);
            chk("T3 gnt", gnt_a, eg);
            chk("T3 gnt_b", gnt_b, eg);
        end

        // T4: m1 write-back then refill with enable held
        do_reset();
        cyc(0, 0, 0, 1, 1, 32'h800, 0);
        chk("T4 gnt_c0", gnt_a, 2'b00);
        cyc(0, 0, 0, 1, 1, 32'h800, 0);
        chk("T4 gnt_wb", gnt_a, 2'b10);
        chk("T4 wr_wb", iam.write, 1'b1);
        chk("T4 addr_wb", iam.addr, 32'h800);
        cyc(0, 0, 0, 1, 1, 32'h800, 1);
        chk("T4 ack_wb", ia1.ack, 1'b1);
        cyc(0, 0, 0, 1, 0, 32'h420, 0);
        chk("T4 gnt_gap", gnt_a, 2'b00);
        cyc(0, 0, 0, 1, 0, 32'h420, 0);
        chk("T4 gnt_rf", gnt_a, 2'b10);
        chk("T4 wr_rf", iam.write, 1'b0);
        chk("T4 addr_rf", iam.addr, 32'h420);
        cyc(0, 0, 0, 1, 0, 32'h420, 1);
        chk("T4 ack_rf", ia1.ack, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("T4 gnt_end", gnt_a, 2'b00);

        // T5: abort after 2 granted cycles, then a stray ack while idle
        do_reset();
        cyc(1, 0, 32'h40, 0, 0, 0, 0);
        chk("T5 gnt_c0", gnt_a, 2'b00);
        for (int k = 1; k <= 2; k++) begin
            cyc(1, 0, 32'h40, 0, 0, 0, 0);
            chk("T5 gnt", gnt_a, 2'b01);
            chk("T5 mem_en", iam.enable, 1'b1);
        end
        cyc(0, 0, 32'h40, 0, 0, 0, 0);
        chk("T5 mem_en_abort", iam.enable, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("T5 gnt_idle", gnt_a, 2'b00);
        chk("T5 idle_ack0", ia0.ack, 1'b0);
        chk("T5 idle_ack1", ia1.ack, 1'b0);
        chk("T5 err", err_a, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("T5 gnt_after", gnt_a, 2'b00);

        // T6 (8-cycle watchdog): ack on cycle 8 completes, then a real timeout
        do_reset();
        cyc(0, 0, 0, 1, 0, 32'h420, 0);
        chk("T6 gnt_c0", gnt_b, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 1, 0, 32'h420, k == 8);
            chk("T6 gnt_ack8", gnt_b, 2'b10);
            chk("T6 ack1_ack8", ib1.ack, k == 8);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("T6 gnt_after_ack8", gnt_b, 2'b00);
        chk("T6 err_after_ack8", err_b, 1'b0);
        cyc(1, 0, 32'h40, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 32'h40, 0, 0, 0, 0);
            chk("T6 gnt_tmo", gnt_b, 2'b01);
            chk("T6 ack0_tmo", ib0.ack, 1'b0);
            chk("T6 err_pre", err_b, 1'b0);
        end
        cyc(1, 0, 32'h40, 1, 0, 32'h420, 0);
        chk("T6 gnt_after_tmo", gnt_b, 2'b00);
        chk("T6 err_set", err_b, 1'b1);
        cyc(1, 0, 32'h40, 1, 0, 32'h420, 1);
        chk("T6 rr_after_tmo", gnt_b, 2'b10);
        chk("T6 ack1_rr", ib1.ack, 1'b1);
        cyc(1, 0, 32'h40, 1, 0, 32'h420, 0);
        chk("T6 gnt_gap", gnt_b, 2'b00);
        cyc(1, 0, 32'h40, 1, 0, 32'h420, 0);
        chk("T6 rr_m0", gnt_b, 2'b01);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("T6 err_sticky", err_b, 1'b1);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
